// File: rtl/edid_i2c_serial.sv
// I2C slave front end for an EDID-style register file: decodes the device and
// register address, strobes writes and serves auto-incrementing sequential reads.
module edid_i2c_serial #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sdaOut,
  output logic [7:0] regAddr,
  output logic [7:0] dataToRegIf,
  output logic       writeEn,
  input  logic [7:0] dataFromRegIf
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_REG_ADDR,
    ST_ACK_REG,
    ST_WR_DATA,
    ST_ACK_WR,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  state_e     state_q, state_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       sda_out_q, sda_out_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wen_q, wen_d;

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = sclIn & ~scl_q;
  assign scl_fall  = ~sclIn & scl_q;
  assign start_det = sclIn & scl_q & sda_q & ~sdaIn;
  assign stop_det  = sclIn & scl_q & ~sda_q & sdaIn;
  assign rx_byte   = {shift_q[6:0], sdaIn};

  // Bit-level protocol: sample on SCL rise, change SDA only on SCL fall.
  // START/STOP are checked first so they win over any coincident SCL edge.
  always_comb begin
    state_d    = state_q;
    scl_d      = sclIn;
    sda_d      = sdaIn;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    sda_out_d  = sda_out_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    wen_d      = 1'b0;

    if (start_det) begin
      state_d   = ST_DEV_ADDR;
      cnt_d     = 4'd0;
      sda_out_d = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end

        ST_DEV_ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw_d = rx_byte[0];
              end else begin
                state_d   = ST_WAIT_STOP;
                sda_out_d = 1'b1;
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_out_d = 1'b0;
            state_d   = ST_ACK_DEV;
          end
        end

        // The falling edge that ends the ACK also starts bit 7 of a read byte.
        ST_ACK_DEV: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (rw_q) begin
              state_d   = ST_RD_DATA;
              sda_out_d = dataFromRegIf[7];
              tx_d      = {dataFromRegIf[6:0], 1'b0};
            end else begin
              state_d   = ST_REG_ADDR;
              sda_out_d = 1'b1;
            end
          end
        end

        ST_REG_ADDR: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              reg_addr_d = rx_byte;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_out_d = 1'b0;
            state_d   = ST_ACK_REG;
          end
        end

        ST_ACK_REG: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              wdata_d = rx_byte;
              wen_d   = 1'b1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_out_d = 1'b0;
            state_d   = ST_ACK_WR;
          end
        end

        ST_ACK_WR: begin
          if (scl_fall) begin
            sda_out_d  = 1'b1;
            reg_addr_d = reg_addr_q + 8'd1;
            cnt_d      = 4'd0;
            state_d    = ST_WR_DATA;
          end
        end

        ST_RD_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_out_d  = 1'b1;
              reg_addr_d = reg_addr_q + 8'd1;
              cnt_d      = 4'd0;
              state_d    = ST_RD_ACK;
            end else begin
              sda_out_d = tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
            end
          end
        end

        // cnt_q == 1 marks a master ACK seen on the rising edge.
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sdaIn) begin
              state_d   = ST_WAIT_STOP;
              sda_out_d = 1'b1;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d     = 4'd0;
            state_d   = ST_RD_DATA;
            sda_out_d = dataFromRegIf[7];
            tx_d      = {dataFromRegIf[6:0], 1'b0};
          end
        end

        ST_WAIT_STOP: begin
        end

        default: begin
          state_d   = ST_IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      sda_out_q  <= 1'b1;
      reg_addr_q <= 8'h00;
      wdata_q    <= 8'h00;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      sda_out_q  <= sda_out_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
    end
  end

  assign sdaOut      = sda_out_q;
  assign regAddr     = reg_addr_q;
  assign dataToRegIf = wdata_q;
  assign writeEn     = wen_q;

endmodule
